// File: rtl/counter_bus_arb_if.sv
// Counter peripheral register bus bundle for the two-master arbiter.
// Carries both master-side ports (m0, m1) and the single slave-side port.
// The "slave" modport is the arbiter's view: it is the slave of both masters
// and drives the peripheral. The "master" modport is the view of the
// surrounding environment (bus masters plus the counter peripheral).
interface counter_bus_arb_if;
  // master 0
  logic        i_m0_select;
  logic        i_m0_wr;
  logic [3:0]  i_m0_addr;
  logic [15:0] i_m0_data;
  logic [15:0] o_m0_data;
  logic        o_m0_ack;
  logic        o_m0_err;
  // master 1
  logic        i_m1_select;
  logic        i_m1_wr;
  logic [3:0]  i_m1_addr;
  logic [15:0] i_m1_data;
  logic [15:0] o_m1_data;
  logic        o_m1_ack;
  logic        o_m1_err;
  // peripheral side
  logic        o_bus_select;
  logic        o_bus_wr;
  logic [3:0]  o_reg_addr;
  logic [15:0] o_bus_data;
  logic [15:0] i_bus_data;
  logic        i_bus_ack;

  modport slave (
    input  i_m0_select, i_m0_wr, i_m0_addr, i_m0_data,
    output o_m0_data, o_m0_ack, o_m0_err,
    input  i_m1_select, i_m1_wr, i_m1_addr, i_m1_data,
    output o_m1_data, o_m1_ack, o_m1_err,
    output o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
    input  i_bus_data, i_bus_ack
  );

  modport master (
    output i_m0_select, i_m0_wr, i_m0_addr, i_m0_data,
    input  o_m0_data, o_m0_ack, o_m0_err,
    output i_m1_select, i_m1_wr, i_m1_addr, i_m1_data,
    input  o_m1_data, o_m1_ack, o_m1_err,
    input  o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
    output i_bus_data, i_bus_ack
  );
endinterface

// File: rtl/counter_bus_arb.sv
// counter_bus_arb: two-master round-robin arbiter in front of the counter
// peripheral register bus. The winning command is latched and held on the
// peripheral side until ack; read data and a one-cycle ack go back to the
// owner only. Flow: IDLE (grant) -> BUSY (command on bus) -> RESP (one
// recovery cycle so the owner can drop select) -> IDLE.
// Optional build macro: COUNTER_ARB_TIMEOUT_EN adds a slave-ack watchdog of
// TIMEOUT_CYC BUSY cycles; on expiry the owner gets ack with err=1, data 0.
module counter_bus_arb #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               i_sysclk,
  input  logic               i_sysrst,
  counter_bus_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;        // index of the master granted most recently
  logic        owner_q;       // index of the master owning the current transfer
  logic        bus_select_q;
  logic        bus_wr_q;
  logic [3:0]  reg_addr_q;
  logic [15:0] bus_data_q;
  logic [15:0] m0_data_q;
  logic [15:0] m1_data_q;
  logic        m0_ack_q;
  logic        m1_ack_q;

  // Winner selection, evaluated only when the FSM is in IDLE.
  logic        req_any_s;
  logic        winner_s;
  logic        win_wr_s;
  logic [3:0]  win_addr_s;
  logic [15:0] win_data_s;

`ifdef COUNTER_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  logic [7:0]  wait_cnt_q;
  logic        m0_err_q;
  logic        m1_err_q;
  logic        expire_s;
`endif

  // Round-robin pick: on a tie the master not served last wins.
  always_comb begin
    req_any_s  = bus.i_m0_select | bus.i_m1_select;
    winner_s   = 1'b0;
    win_wr_s   = 1'b0;
    win_addr_s = 4'h0;
    win_data_s = 16'h0000;
    if (bus.i_m0_select && bus.i_m1_select) begin
      winner_s = ~last_q;
    end else if (bus.i_m1_select) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (winner_s) begin
      win_wr_s   = bus.i_m1_wr;
      win_addr_s = bus.i_m1_addr;
      win_data_s = bus.i_m1_data;
    end else begin
      win_wr_s   = bus.i_m0_wr;
      win_addr_s = bus.i_m0_addr;
      win_data_s = bus.i_m0_data;
    end
  end

`ifdef COUNTER_ARB_TIMEOUT_EN
  // Watchdog expiry: this BUSY cycle is the last allowed one and no ack came.
  always_comb begin
    expire_s = 1'b0;
    if (state_q == ST_BUSY) begin
      expire_s = !bus.i_bus_ack && ((wait_cnt_q + 8'd1) == TIMEOUT_LIM);
    end else begin
      expire_s = 1'b0;
    end
  end

  // Wait counter: cleared on entry to BUSY, counts every BUSY cycle.
  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: wait_cnt_q <= 8'd0;
        ST_BUSY: wait_cnt_q <= wait_cnt_q + 8'd1;
        ST_RESP: wait_cnt_q <= 8'd0;
        default: wait_cnt_q <= 8'd0;
      endcase
    end
  end
`endif

  // Main FSM with all outputs registered; acks default low so they pulse.
  always_ff @(posedge i_sysclk or negedge i_sysrst) begin
    if (!i_sysrst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;     // pretend m1 was served last so m0 wins first tie
      owner_q      <= 1'b0;
      bus_select_q <= 1'b0;
      bus_wr_q     <= 1'b0;
      reg_addr_q   <= 4'h0;
      bus_data_q   <= 16'h0000;
      m0_data_q    <= 16'h0000;
      m1_data_q    <= 16'h0000;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
`endif
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_any_s) begin
            state_q      <= ST_BUSY;
            owner_q      <= winner_s;
            last_q       <= winner_s;
            bus_select_q <= 1'b1;
            bus_wr_q     <= win_wr_s;
            reg_addr_q   <= win_addr_s;
            bus_data_q   <= win_data_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus.i_bus_ack) begin
            // Ack wins over a same-cycle watchdog expiry.
            state_q      <= ST_RESP;
            bus_select_q <= 1'b0;
            if (owner_q) begin
              m1_data_q <= bus.i_bus_data;
              m1_ack_q  <= 1'b1;
            end else begin
              m0_data_q <= bus.i_bus_data;
              m0_ack_q  <= 1'b1;
            end
`ifdef COUNTER_ARB_TIMEOUT_EN
          end else if (expire_s) begin
            state_q      <= ST_RESP;
            bus_select_q <= 1'b0;
            if (owner_q) begin
              m1_data_q <= 16'h0000;
              m1_ack_q  <= 1'b1;
              m1_err_q  <= 1'b1;
            end else begin
              m0_data_q <= 16'h0000;
              m0_ack_q  <= 1'b1;
              m0_err_q  <= 1'b1;
            end
`endif
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          bus_select_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bus_select = bus_select_q;
  assign bus.o_bus_wr     = bus_wr_q;
  assign bus.o_reg_addr   = reg_addr_q;
  assign bus.o_bus_data   = bus_data_q;
  assign bus.o_m0_data    = m0_data_q;
  assign bus.o_m1_data    = m1_data_q;
  assign bus.o_m0_ack     = m0_ack_q;
  assign bus.o_m1_ack     = m1_ack_q;
`ifdef COUNTER_ARB_TIMEOUT_EN
  assign bus.o_m0_err     = m0_err_q;
  assign bus.o_m1_err     = m1_err_q;
`else
  assign bus.o_m0_err     = 1'b0;
  assign bus.o_m1_err     = 1'b0;
`endif

endmodule
